// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART byte transmitter among NUM_REQ sources.
// First byte reaches tx_valid 2 cycles after req; tx_valid/tx_data hold until tx_ready, and a stalled owner is released by a watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [OW-1:0] OWNER_MAX = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;
  logic [WW-1:0]        wdog_q, wdog_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 pick_vld;
  logic [OW-1:0]        pick_idx;

  // Scan from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = OW'((int'(last_owner_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    req_ack_d     = '0;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    wdog_d        = wdog_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          wdog_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (req[owner_q]) begin
          tx_data_d  = req_data[8*owner_q +: 8];
          last_d     = req_last[owner_q];
          tx_valid_d = 1'b1;
          req_ack_d  = grant_q;
          state_d    = SEND;
        end else if (wdog_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          grant_d       = '0;
          last_owner_d  = owner_q;
          state_d       = IDLE;
        end else begin
          // Release fires at WD_LAST, so the counter never needs to wrap.
          wdog_d = wdog_q + 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            grant_d      = '0;
            last_owner_d = owner_q;
            state_d      = IDLE;
          end else begin
            wdog_d  = '0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      req_ack_q     <= '0;
      owner_q       <= '0;
      last_owner_q  <= OWNER_MAX;
      wdog_q        <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      req_ack_q     <= req_ack_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wdog_q        <= wdog_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign req_ack     = req_ack_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requester agents, a transfer log, and a message-level
// round-robin reference model for randomized traffic.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   req_ack, grant;
  logic           tx_valid, busy, timeout_err;
  logic [7:0]     tx_data;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 1;             // 0: low, 1: high, 2: random
  logic [8:0]   srcq [N][$];    // {last, byte} pending per requester
  logic [N+7:0] xlog [$];       // {grant, byte} per transfer
  int ack_cnt [N] = '{default: 0};
  int tmo_cnt = 0;
  logic [8:0]   mq [N][$];
  logic [N+7:0] expq [$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Agents and monitor act on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    logic r;
    r = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
    tx_ready = r;
    if (reset_n) begin
      if (tx_valid && r) xlog.push_back({grant, tx_data});
      if (timeout_err) tmo_cnt++;
      for (int i = 0; i < N; i++)
        if (req_ack[i]) begin
          ack_cnt[i]++;
          if (srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
    end
    for (int i = 0; i < N; i++) begin
      req[i]            = (srcq[i].size() > 0);
      req_data[8*i +: 8] = req[i] ? srcq[i][0][7:0] : 8'h00;
      req_last[i]       = req[i] ? srcq[i][0][8] : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({grant, req_ack, tx_valid, tx_data, busy, timeout_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {grant, req_ack, tx_valid, tx_data, busy, timeout_err});
    end
    reset_n = 1'b1;
    repeat (3) tick();
    tests++;
    if ({grant, busy, tx_valid} !== '0) begin
      fails++;
      $display("FAIL idle_no_req: got %h want 0", {grant, busy, tx_valid});
    end
  endtask

  task automatic test_single();
    int xb, ab;
    bit bad_grant, idle_ok;
    xb = xlog.size();
    ab = ack_cnt[0];
    bad_grant = 1'b0;
    idle_ok = 1'b0;
    rdy_mode = 1;
    srcq[0].push_back(9'h041);
    srcq[0].push_back(9'h042);
    srcq[0].push_back(9'h143);
    tick();
    tests++;
    if ({grant, busy, tx_valid} !== {3'b001, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL single_grant_edge: got %b want 00110", {grant, busy, tx_valid});
    end
    tick();
    tests++;
    if ({tx_valid, req_ack, tx_data} !== {1'b1, 3'b001, 8'h41}) begin
      fails++;
      $display("FAIL single_first_byte: got %h want %h", {tx_valid, req_ack, tx_data}, {1'b1, 3'b001, 8'h41});
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (busy && grant !== 3'b001) bad_grant = 1'b1;
      if (xlog.size() == xb + 3) begin
        idle_ok = !busy && (grant == 3'b000);
        break;
      end
    end
    tests++;
    if (bad_grant || !idle_ok) begin
      fails++;
      $display("FAIL single_grant_idle: got bad_grant=%0d idle=%0d want 0 1", bad_grant, idle_ok);
    end
    for (int j = 0; j < 3; j++) begin
      logic [N+7:0] got, want;
      want = {3'b001, 8'(8'h41 + j)};
      got  = (xb + j < xlog.size()) ? xlog[xb+j] : 'x;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL single_byte%0d: got %h want %h", j, got, want);
      end
    end
    tests++;
    if (ack_cnt[0] - ab != 3) begin
      fails++;
      $display("FAIL single_acks: got %0d want 3", ack_cnt[0] - ab);
    end
  endtask

  task automatic test_round_robin();
    int xb;
    bit ok;
    do_reset();
    rdy_mode = 1;
    xb = xlog.size();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'(8'h10 * (i + 1) + m)});
    drain(200, ok);
    tests++;
    if (!ok || xlog.size() != xb + 6) begin
      fails++;
      $display("FAIL rr_count: got %0d (done=%0d) want 6", xlog.size() - xb, ok);
    end
    for (int j = 0; j < 6; j++) begin
      logic [N+7:0] got, want;
      want = {N'(1) << (j % 3), 8'(8'h10 * ((j % 3) + 1) + j / 3)};
      got  = (xb + j < xlog.size()) ? xlog[xb+j] : 'x;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL rr_entry%0d: got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_no_interleave();
    int xb, ab;
    bit seen, ok;
    xb = xlog.size();
    ab = ack_cnt[2];
    seen = 1'b0;
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) srcq[2].push_back({(b == 3), 8'(8'hC0 + b)});
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack_cnt[2] > ab) begin
        seen = 1'b1;
        break;
      end
    end
    srcq[0].push_back(9'h155);
    drain(200, ok);
    tests++;
    if (!seen || !ok || xlog.size() != xb + 5) begin
      fails++;
      $display("FAIL ni_count: got %0d (ack=%0d done=%0d) want 5", xlog.size() - xb, seen, ok);
    end
    for (int j = 0; j < 5; j++) begin
      logic [N+7:0] got, want;
      want = (j < 4) ? {3'b100, 8'(8'hC0 + j)} : {3'b001, 8'h55};
      got  = (xb + j < xlog.size()) ? xlog[xb+j] : 'x;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ni_entry%0d: got %h want %h", j, got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    int xb, ab, tb0, unstable;
    bit seen, ok;
    xb = xlog.size();
    tb0 = tmo_cnt;
    unstable = 0;
    seen = 1'b0;
    rdy_mode = 0;
    srcq[1].push_back(9'h0A1);
    srcq[1].push_back(9'h1A2);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    ab = ack_cnt[1];
    repeat (20) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== 8'hA1) unstable++;
    end
    tests++;
    if (!seen || unstable != 0) begin
      fails++;
      $display("FAIL bp_stable: got unstable=%0d seen=%0d want 0 1", unstable, seen);
    end
    tests++;
    if (ack_cnt[1] - ab != 1) begin
      fails++;
      $display("FAIL bp_acks: got %0d want 1", ack_cnt[1] - ab);
    end
    rdy_mode = 1;
    tick();
    tests++;
    if (tx_valid !== 1'b0 || xlog.size() != xb + 1) begin
      fails++;
      $display("FAIL bp_release: got valid=%b xfers=%0d want 0 1", tx_valid, xlog.size() - xb);
    end
    drain(100, ok);
    tests++;
    if (!ok || xlog.size() != xb + 2 || xlog[xb] !== {3'b010, 8'hA1} || xlog[xb+1] !== {3'b010, 8'hA2}) begin
      fails++;
      $display("FAIL bp_bytes: got %0d xfers want 2 (010a1, 010a2)", xlog.size() - xb);
    end
    tests++;
    if (tmo_cnt != tb0) begin
      fails++;
      $display("FAIL bp_timeout: got %0d want 0", tmo_cnt - tb0);
    end
  endtask

  task automatic test_watchdog();
    int xb, tb0;
    bit seen, ok;
    do_reset();
    rdy_mode = 1;
    xb = xlog.size();
    tb0 = tmo_cnt;
    seen = 1'b0;
    srcq[1].push_back(9'h077);
    srcq[2].push_back(9'h199);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (xlog.size() == xb + 1) begin
        seen = 1'b1;
        break;
      end
    end
    for (int c = 1; c <= TO + 1; c++) begin
      tick();
      if (c == TO - 1) begin
        tests++;
        if (timeout_err !== 1'b0 || grant !== 3'b010) begin
          fails++;
          $display("FAIL wd_early: got err=%b grant=%b want 0 010", timeout_err, grant);
        end
      end
      if (c == TO) begin
        tests++;
        if (!seen || timeout_err !== 1'b1 || grant !== 3'b000) begin
          fails++;
          $display("FAIL wd_fire: got err=%b grant=%b want 1 000", timeout_err, grant);
        end
      end
      if (c == TO + 1) begin
        tests++;
        if (grant !== 3'b100) begin
          fails++;
          $display("FAIL wd_next_grant: got %b want 100", grant);
        end
      end
    end
    drain(100, ok);
    tests++;
    if (tmo_cnt - tb0 != 1) begin
      fails++;
      $display("FAIL wd_pulses: got %0d want 1", tmo_cnt - tb0);
    end
    tests++;
    if (!ok || xlog.size() != xb + 2 || xlog[xb] !== {3'b010, 8'h77} || xlog[xb+1] !== {3'b100, 8'h99}) begin
      fails++;
      $display("FAIL wd_bytes: got %0d xfers want 2 (01077, 10099)", xlog.size() - xb);
    end
  endtask

  task automatic test_async_reset();
    int xb;
    bit seen, ok;
    rdy_mode = 0;
    seen = 1'b0;
    srcq[0].push_back(9'h15A);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (!seen || {grant, req_ack, tx_valid, tx_data, busy, timeout_err} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h (seen=%0d) want 0", {grant, req_ack, tx_valid, tx_data, busy, timeout_err}, seen);
    end
    srcq[1].push_back(9'h1B1);
    srcq[2].push_back(9'h1C2);
    repeat (2) tick();
    xb = xlog.size();
    rdy_mode = 1;
    reset_n = 1'b1;
    tick();
    tests++;
    if (grant !== 3'b001) begin
      fails++;
      $display("FAIL async_priority: got %b want 001", grant);
    end
    drain(100, ok);
    for (int j = 0; j < 3; j++) begin
      logic [N+7:0] got, want;
      want = (j == 0) ? {3'b001, 8'h5A} : (j == 1) ? {3'b010, 8'hB1} : {3'b100, 8'hC2};
      got  = (ok && xb + j < xlog.size()) ? xlog[xb+j] : 'x;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL async_entry%0d: got %h want %h", j, got, want);
      end
    end
  endtask

  // Reference: whole messages granted to the next non-empty source after the previous owner.
  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      int xb, last;
      bit ok, found;
      do_reset();
      rdy_mode = 2;
      xb = xlog.size();
      expq.delete();
      for (int i = 0; i < N; i++) begin
        int nmsg;
        nmsg = $urandom_range(1, 3);
        for (int m = 0; m < nmsg; m++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            logic [8:0] e;
            e = {(b == len - 1), 8'($urandom)};
            srcq[i].push_back(e);
            mq[i].push_back(e);
          end
        end
      end
      last = N - 1;
      found = 1'b1;
      while (found) begin
        found = 1'b0;
        for (int k = 1; k <= N && !found; k++) begin
          int i;
          i = (last + k) % N;
          if (mq[i].size() > 0) begin
            logic [8:0] e;
            do begin
              e = mq[i].pop_front();
              expq.push_back({N'(1) << i, e[7:0]});
            end while (!e[8]);
            last = i;
            found = 1'b1;
          end
        end
      end
      drain(2000, ok);
      tests++;
      if (!ok || xlog.size() != xb + expq.size()) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d want %0d", round, xlog.size() - xb, expq.size());
      end
      for (int j = 0; j < expq.size(); j++) begin
        logic [N+7:0] got;
        got = (xb + j < xlog.size()) ? xlog[xb+j] : 'x;
        tests++;
        if (got !== expq[j]) begin
          fails++;
          $display("FAIL rand%0d_entry%0d: got %h want %h", round, j, got, expq[j]);
        end
      end
    end
    rdy_mode = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single UART byte transmitter among `NUM_REQ` message sources (for example the button banner, the RX echo and status reports).
- Requesters are served in round-robin order at message granularity: once granted, a source keeps the transmitter until its byte flagged `last` has been handed off.
- A per-byte watchdog releases a source that stalls mid-message.
- The block sits between the requesters and the byte-level TX engine, which it drives through a valid/ready handshake.

## Interface

- `NUM_REQ`, default 3: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 65535: cycles an owner may leave `req` low mid-message before it is released. Minimum 2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: requester i has a byte pending on `req_data`.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: requester i's current byte ends its message.
- `req_ack` out NUM_REQ: one-cycle pulse; the owner's current byte has been taken, so it presents the next one.
- `grant` out NUM_REQ: one-hot current owner; all zeros when idle.
- `tx_valid` out 1: `tx_data` holds a byte for the TX engine.
- `tx_data` out 8: byte to transmit.
- `tx_ready` in 1: TX engine can accept a byte. A transfer occurs on any clk edge with `tx_valid` and `tx_ready` both high.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: one-cycle pulse when the watchdog releases an owner.

## Operation

- **State machine: IDLE, FETCH, SEND.**
- **IDLE**
  - If `req` is non-zero, pick the first set bit scanning upward from `last_owner+1` (mod `NUM_REQ`).
  - Register `grant` with that bit, clear the watchdog, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - If `req[owner]` = 1:
    - Latch `req_data[owner]` into `tx_data`.
    - Latch `req_last[owner]` into an internal `last_q`.
    - Set `tx_valid` = 1, pulse `req_ack[owner]`, go to SEND.
  - If `req[owner]` = 0:
    - Increment the watchdog.
    - When it reaches `TIMEOUT_CYCLES-1`: pulse `timeout_err`, clear `grant`, set `last_owner` = owner, go to IDLE.
- **SEND**
  - Hold `tx_valid` and `tx_data` stable until the transfer.
  - On the transfer edge, clear `tx_valid`.
  - If `last_q` = 1: clear `grant`, set `last_owner` = owner, go to IDLE.
  - Otherwise clear the watchdog and go to FETCH.
- **Fixed rules**
  - Only the owner's inputs are sampled. `req`, `req_data` and `req_last` from non-owners are ignored.
  - An owner deasserting `req` while in SEND has no effect on the byte in flight.
  - Messages have unbounded length. Fairness applies between messages, not bytes.
  - After a release, a requester still asserting `req` competes again in IDLE; it has the lowest priority on the next scan.
- **Widths**
  - The watchdog is `$clog2(TIMEOUT_CYCLES)` bits and saturates. It cannot wrap before the release.
  - `last_owner` is `$clog2(NUM_REQ)` bits and wraps from `NUM_REQ-1` to 0.

## Timing

- **Reset values:**
  - `grant`, `req_ack`, `tx_valid`, `tx_data`, `busy` and `timeout_err` all = 0.
  - State = IDLE.
  - `last_owner` = `NUM_REQ-1`, so requester 0 wins first after reset.
- **Reset mid-operation:** `tx_valid` drops asynchronously and the byte in flight is abandoned.
- **Request to first byte (edge k = first edge `req` is sampled high in IDLE):**
  - `grant` and `busy` are high after edge k.
  - `tx_valid` and the `req_ack` pulse are high after edge k+1.
  - The first byte therefore appears 2 cycles after the request.
- **Between bytes:** the transfer at edge t returns the state to FETCH. If `req` is still high, the next `tx_valid` is high after edge t+1, giving one idle `tx_valid` cycle between bytes.
- **Back-to-back messages:** IDLE costs one cycle after the last transfer. The next `grant` follows at edge t+1 and `tx_valid` at edge t+2.
- **Acknowledge timing:** `req_ack` rises in the same cycle that `tx_valid` rises. The requester must present the next byte, or drop `req`, by the edge the FETCH state next samples.
- **Ready already high:** if `tx_ready` is already high when `tx_valid` rises, the transfer completes on the next edge, so SEND lasts 1 cycle.
- **Timeout:** `timeout_err` is high for exactly one cycle, coincident with `grant` clearing. Measured from entry to FETCH, this is `TIMEOUT_CYCLES` cycles.

## Test plan

All scenarios use `NUM_REQ`=3 and `TIMEOUT_CYCLES`=16.

1. **Single message after reset.**
   - Stimulus: release reset; req0 sends 3 bytes 0x41/0x42/0x43 (last on 0x43); `tx_ready` tied high.
   - Required response: `tx_data` sequence 41,42,43; 3 `req_ack[0]` pulses; `grant` = 001 throughout; IDLE after the 3rd transfer; first `tx_valid` 2 cycles after `req`.
2. **Round-robin.**
   - Stimulus: req0, req1 and req2 all request 1-byte messages (0x10, 0x20, 0x30) continuously.
   - Required response: service order 0,1,2,0; no requester is served twice in a row.
3. **No interleaving mid-message.**
   - Stimulus: req2 sends 4 bytes while req0 asserts from the 2nd byte onward.
   - Required response: all 4 of req2's bytes are transmitted contiguously, then `grant` = 001.
4. **Backpressure.**
   - Stimulus: `tx_ready` is held low for 20 cycles after `tx_valid` rises.
   - Required response: `tx_valid` and `tx_data` stay stable; no further `req_ack`; no timeout; the transfer completes on the first edge after `tx_ready` goes high.
5. **Watchdog.**
   - Stimulus: req1 sends its first byte (not last), then drops `req`.
   - Required response: `timeout_err` pulses once, 16 cycles after FETCH entry; `grant` = 000; a pending req2 is granted next.
6. **Async reset during SEND.**
   - Stimulus: assert `reset_n` low while `tx_valid` = 1.
   - Required response: all outputs become 0 immediately; after release, requester 0 has priority.
